// File: rtl/d_branch_pkg.sv
// Shared types for the decode-stage branch resolver: branch opcodes,
// 2-bit saturating counter encoding and the counter update function.
package d_branch_pkg;

  typedef enum logic [2:0] {
    BOP_NONE = 3'b000,
    BOP_BEQ  = 3'b001,
    BOP_BNE  = 3'b010,
    BOP_BLEZ = 3'b011,
    BOP_BGTZ = 3'b100,
    BOP_BLTZ = 3'b101,
    BOP_BGEZ = 3'b110,
    BOP_RSVD = 3'b111
  } bop_t;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t CTR_SNT = 2'b00;
  localparam ctr2_t CTR_WNT = 2'b01;
  localparam ctr2_t CTR_WT  = 2'b10;
  localparam ctr2_t CTR_ST  = 2'b11;

  // Move a counter one step toward the resolved direction, clamping at the ends.
  function automatic ctr2_t sat_update(input ctr2_t ctr, input logic taken);
    ctr2_t nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/d_bht.sv
// Branch history table: BHT_ENTRIES 2-bit saturating counters indexed by
// pc[IDX_W+1:2]. One combinational read port for fetch, one synchronous
// update port for the resolve stage. A read of the entry being updated in
// the same cycle returns the old value.
module d_bht
  import d_branch_pkg::*;
#(
  parameter int BHT_ENTRIES = 16,
  parameter int PC_W        = 32,
  localparam int IDX_W      = $clog2(BHT_ENTRIES)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [PC_W-1:0]  i_rd_pc,
  output logic             o_rd_pred,
  input  logic             i_upd_en,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken
);

  ctr2_t ctr_q [BHT_ENTRIES];
  ctr2_t ctr_d [BHT_ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic             unused_rd_bits;

  assign rd_idx         = i_rd_pc[IDX_W+1:2];
  assign o_rd_pred      = ctr_q[rd_idx][1];
  assign unused_rd_bits = ^{i_rd_pc[PC_W-1:IDX_W+2], i_rd_pc[1:0]};

  // Next counter array: only the addressed entry moves on an update.
  always_comb begin
    ctr_d = ctr_q;
    if (i_upd_en) ctr_d[i_upd_idx] = sat_update(ctr_q[i_upd_idx], i_upd_taken);
  end

  // Counter storage, all entries start weakly not taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) ctr_q[i] <= CTR_WNT;
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/d_branch_resolve.sv
// Decode-stage branch resolver with a registered resolve stage and a
// PC-indexed 2-bit counter predictor read by fetch.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
//
// Handshake: i_valid qualifies the decode inputs for one cycle; there is no
// ready. i_stall freezes the resolve stage (the decode inputs are ignored),
// i_flush drops whatever would enter it and wins over i_stall. A resolved
// branch trains the table on the first edge it sits in the resolve stage
// with i_stall low, so each branch trains exactly once.
module d_branch_resolve
  import d_branch_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PC_W        = 32,
  parameter int BHT_ENTRIES = 16,
  localparam int IDX_W      = $clog2(BHT_ENTRIES)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [2:0]        i_con_bop,
  input  logic [DATA_W-1:0] i_data_rs,
  input  logic [DATA_W-1:0] i_data_rt,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [PC_W-1:0]   i_target,
  input  logic              i_pred_taken,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic [PC_W-1:0]   i_fetch_pc,
  output logic              o_pred_taken,
  output logic              o_res_valid,
  output logic              o_con_ifbranch,
  output logic              o_mispredict,
  output logic [PC_W-1:0]   o_redirect_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       o_branch_cnt,
  output logic [31:0]       o_mispred_cnt
`endif
);

  bop_t bop;
  logic is_br;
  logic cond;
  logic rs_zero;
  logic rs_neg;

  logic             res_valid_q, res_valid_d;
  logic             taken_q, taken_d;
  logic             mispred_q, mispred_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PC_W-1:0]  redirect_q, redirect_d;

  logic upd_en;

  assign bop     = bop_t'(i_con_bop);
  assign rs_zero = (i_data_rs == '0);
  assign rs_neg  = i_data_rs[DATA_W-1];

  // Branch condition evaluation on the forwarded operands.
  always_comb begin
    is_br = 1'b1;
    cond  = 1'b0;
    case (bop)
      BOP_BEQ:  cond = (i_data_rs == i_data_rt);
      BOP_BNE:  cond = (i_data_rs != i_data_rt);
      BOP_BLEZ: cond = rs_zero | rs_neg;
      BOP_BGTZ: cond = ~rs_zero & ~rs_neg;
      BOP_BLTZ: cond = rs_neg;
      BOP_BGEZ: cond = ~rs_neg;
      default:  is_br = 1'b0;
    endcase
  end

  // Resolve-stage next state: flush clears, stall holds, else capture.
  // taken/mispredict are cleared alongside valid so they read 0 when idle.
  always_comb begin
    res_valid_d = res_valid_q;
    taken_d     = taken_q;
    mispred_d   = mispred_q;
    idx_d       = idx_q;
    redirect_d  = redirect_q;
    if (i_flush) begin
      res_valid_d = 1'b0;
      taken_d     = 1'b0;
      mispred_d   = 1'b0;
    end else if (!i_stall) begin
      res_valid_d = i_valid & is_br;
      taken_d     = res_valid_d & cond;
      mispred_d   = res_valid_d & (cond ^ i_pred_taken);
      idx_d       = i_pc[IDX_W+1:2];
      redirect_d  = cond ? i_target : i_pc + PC_W'(4);
    end
  end

  // Resolve-stage registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      mispred_q   <= 1'b0;
      idx_q       <= '0;
      redirect_q  <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      taken_q     <= taken_d;
      mispred_q   <= mispred_d;
      idx_q       <= idx_d;
      redirect_q  <= redirect_d;
    end
  end

  assign upd_en         = res_valid_q & ~i_stall;
  assign o_res_valid    = res_valid_q;
  assign o_con_ifbranch = taken_q;
  assign o_mispredict   = mispred_q;
  assign o_redirect_pc  = redirect_q;

  d_bht #(
    .BHT_ENTRIES (BHT_ENTRIES),
    .PC_W        (PC_W)
  ) u_bht (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rd_pc     (i_fetch_pc),
    .o_rd_pred   (o_pred_taken),
    .i_upd_en    (upd_en),
    .i_upd_idx   (idx_q),
    .i_upd_taken (taken_q)
  );

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  // Saturating event counters advanced on each table training edge.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_en) begin
      if (branch_cnt_q != 32'hFFFF_FFFF) branch_cnt_d = branch_cnt_q + 32'd1;
      if (mispred_q && (mispred_cnt_q != 32'hFFFF_FFFF)) mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign o_branch_cnt  = branch_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;
`endif

endmodule
